gray_conv_sched: RTL and testbench

GRAY_CONV_SCHED -- requirements
Module: gray_conv_sched

---
 rtl/gray_conv_sched_if.sv | 36 +++
 rtl/gray_conv_sched.sv | 143 ++++++++++++++
 tb/tb_gray_conv_sched.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gray_conv_sched_if.sv
// Bundle of ports for gray_conv_sched: two RGB camera sources, the shared grayscale unit and the output stream.
interface gray_conv_sched_if;
    logic       en_i;
    logic       s0_valid_i, s1_valid_i;
    logic [7:0] s0_red_i, s0_green_i, s0_blue_i;
    logic [7:0] s1_red_i, s1_green_i, s1_blue_i;
    logic       s0_ready_o, s1_ready_o;
    logic [7:0] conv_red_o, conv_green_o, conv_blue_o;
    logic       conv_start_o;
    logic [7:0] conv_gray_i;
    logic       conv_done_i;
    logic       m_valid_o, m_ready_i;
    logic [7:0] m_gray_o;
    logic       m_src_o, m_last_o;
    logic       err_o;

    modport slave (
        input  en_i, s0_valid_i, s1_valid_i,
        input  s0_red_i, s0_green_i, s0_blue_i, s1_red_i, s1_green_i, s1_blue_i,
        output s0_ready_o, s1_ready_o,
        output conv_red_o, conv_green_o, conv_blue_o, conv_start_o,
        input  conv_gray_i, conv_done_i,
        output m_valid_o, m_gray_o, m_src_o, m_last_o, err_o,
        input  m_ready_i
    );

    modport master (
        output en_i, s0_valid_i, s1_valid_i,
        output s0_red_i, s0_green_i, s0_blue_i, s1_red_i, s1_green_i, s1_blue_i,
        input  s0_ready_o, s1_ready_o,
        input  conv_red_o, conv_green_o, conv_blue_o, conv_start_o,
        output conv_gray_i, conv_done_i,
        input  m_valid_o, m_gray_o, m_src_o, m_last_o, err_o,
        output m_ready_i
    );
endinterface

// File: rtl/gray_conv_sched.sv
// Round-robin scheduler sharing one grayscale unit between two camera sources,
// with a tag pipeline aligned to the unit latency and a 4-entry result FIFO.
module gray_conv_pix_cnt #(
    parameter int FRAME_PIXELS = 307200,
    parameter int CW           = 19
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    output logic last
);
    logic [CW-1:0] cnt;

    assign last = (cnt == CW'(FRAME_PIXELS - 1));

    always_ff @(posedge clk) begin
        if (rst)      cnt <= '0;
        else if (inc) cnt <= last ? '0 : cnt + 1'b1;
    end
endmodule

module gray_conv_sched #(
    parameter int FRAME_PIXELS = 307200,
    parameter int CW           = 19
) (
    input  logic              clk,
    input  logic              rst,
    gray_conv_sched_if.slave  bus
);
    typedef struct packed {
        logic src;
        logic last;
    } tag_t;

    typedef struct packed {
        logic [7:0] gray;
        tag_t       tag;
    } res_t;

    logic [1:0]      valid, ready, hs, pix_last;
    logic [1:0][7:0] red, green, blue;
    logic            gsel, rr_last, issue, push, pop, m_valid, err;
    logic [2:1]      vld_pipe;
    tag_t [2:1]      tag_pipe;
    logic [1:0]      inflight, wr_ptr, rd_ptr;
    logic [2:0]      occ;
    res_t            fifo [4];
    logic [7:0]      conv_red, conv_green, conv_blue;
    logic            conv_start;

    assign valid = {bus.s1_valid_i, bus.s0_valid_i};
    assign red   = {bus.s1_red_i,   bus.s0_red_i};
    assign green = {bus.s1_green_i, bus.s0_green_i};
    assign blue  = {bus.s1_blue_i,  bus.s0_blue_i};

    // Reserve a FIFO slot at grant time so a returning result can never find the FIFO full.
    assign inflight = 2'(vld_pipe[1]) + 2'(vld_pipe[2]);
    assign issue    = bus.en_i && ((occ + 3'(inflight)) < 3'd4);

    always_comb begin
        ready = '0;
        if (!rst && issue) begin
            if (valid == 2'b11) ready[~rr_last] = 1'b1;
            else                ready = valid;
        end
    end

    assign hs   = valid & ready;
    assign gsel = hs[1];

    generate
        for (genvar i = 0; i < 2; i++) begin : g_cnt
            gray_conv_pix_cnt #(.FRAME_PIXELS(FRAME_PIXELS), .CW(CW)) u_cnt (
                .clk  (clk),
                .rst  (rst),
                .inc  (hs[i]),
                .last (pix_last[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last    <= 1'b1;
            conv_red   <= '0;
            conv_green <= '0;
            conv_blue  <= '0;
            conv_start <= 1'b0;
            vld_pipe   <= '0;
            tag_pipe   <= '0;
        end else begin
            conv_start  <= |hs;
            vld_pipe    <= {vld_pipe[1], |hs};
            tag_pipe[1] <= '{src: gsel, last: pix_last[gsel]};
            tag_pipe[2] <= tag_pipe[1];
            if (|hs) begin
                rr_last    <= gsel;
                conv_red   <= red[gsel];
                conv_green <= green[gsel];
                conv_blue  <= blue[gsel];
            end
        end
    end

    // A done without a pending tag, or a pending tag without a done, are both protocol errors.
    assign push = vld_pipe[2] && bus.conv_done_i;

    always_ff @(posedge clk) begin
        if (rst)                                  err <= 1'b0;
        else if (bus.conv_done_i != vld_pipe[2]) err <= 1'b1;
    end

    assign m_valid = !rst && (occ != 3'd0);
    assign pop     = m_valid && bus.m_ready_i;

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= '{gray: bus.conv_gray_i, tag: tag_pipe[2]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            occ <= occ + 3'(push) - 3'(pop);
        end
    end

    assign bus.s0_ready_o   = ready[0];
    assign bus.s1_ready_o   = ready[1];
    assign bus.conv_red_o   = conv_red;
    assign bus.conv_green_o = conv_green;
    assign bus.conv_blue_o  = conv_blue;
    assign bus.conv_start_o = conv_start;
    assign bus.m_valid_o    = m_valid;
    assign bus.m_gray_o     = fifo[rd_ptr].gray;
    assign bus.m_src_o      = fifo[rd_ptr].tag.src;
    assign bus.m_last_o     = fifo[rd_ptr].tag.last;
    assign bus.err_o        = err;
endmodule

// File: tb/tb_gray_conv_sched.sv
// Scoreboard bench for gray_conv_sched: directed pixels in, expected {gray, src, last} queued, monitor pops on output handshake.
module tb_gray_conv_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gray_conv_sched_if bus();

    gray_conv_sched #(.FRAME_PIXELS(4), .CW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { logic [7:0] r, g, b; } pix_t;
    typedef struct { logic [7:0] gray; logic src; logic last; } exp_t;

    pix_t q0[$], q1[$];
    exp_t exp_q[$];
    exp_t mon_e;

    int checks = 0, errors = 0, cyc = 0, pop_cnt = 0, hs_cnt0 = 0, hs_cnt1 = 0;
    logic [1:0] hs_q = '0;
    logic       unit_done = 1'b0, block_done = 1'b0, inj_done = 1'b0;
    logic [7:0] unit_gray = '0;

    // Grayscale unit model: fixed-point luma, result one cycle after start.
    function automatic logic [7:0] gray_f(logic [7:0] r, logic [7:0] g, logic [7:0] b);
        int s;
        s = 76 * int'(r) + 149 * int'(g) + 29 * int'(b);
        return 8'(s >> 8);
    endfunction

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        hs_q      <= {bus.s1_valid_i & bus.s1_ready_o, bus.s0_valid_i & bus.s0_ready_o};
        if (bus.s0_valid_i & bus.s0_ready_o) hs_cnt0 <= hs_cnt0 + 1;
        if (bus.s1_valid_i & bus.s1_ready_o) hs_cnt1 <= hs_cnt1 + 1;
        unit_done <= bus.conv_start_o;
        unit_gray <= gray_f(bus.conv_red_o, bus.conv_green_o, bus.conv_blue_o);
    end

    assign bus.conv_done_i = (unit_done & ~block_done) | inj_done;
    assign bus.conv_gray_i = unit_gray;

    // Source feeders: retire the head on a handshake, then present the next pixel.
    always @(negedge clk) begin
        if (hs_q[0] && q0.size() > 0) void'(q0.pop_front());
        if (hs_q[1] && q1.size() > 0) void'(q1.pop_front());
        bus.s0_valid_i = (q0.size() > 0);
        bus.s1_valid_i = (q1.size() > 0);
        if (q0.size() > 0) {bus.s0_red_i, bus.s0_green_i, bus.s0_blue_i} = {q0[0].r, q0[0].g, q0[0].b};
        if (q1.size() > 0) {bus.s1_red_i, bus.s1_green_i, bus.s1_blue_i} = {q1[0].r, q1[0].g, q1[0].b};
    end

    always @(negedge clk) begin
        if (!rst && bus.m_valid_o && bus.m_ready_i) begin
            checks++;
            pop_cnt++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected got gray %0d src %0d last %0d with empty scoreboard",
                         bus.m_gray_o, bus.m_src_o, bus.m_last_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.m_gray_o !== mon_e.gray || bus.m_src_o !== mon_e.src || bus.m_last_o !== mon_e.last) begin
                    errors++;
                    $display("FAIL out_pixel got gray %0d src %0d last %0d expected gray %0d src %0d last %0d",
                             bus.m_gray_o, bus.m_src_o, bus.m_last_o, mon_e.gray, mon_e.src, mon_e.last);
                end
            end
        end
    end

    task automatic chk(string nm, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic px(int s, logic [7:0] r, logic [7:0] g, logic [7:0] b);
        pix_t p;
        p = '{r, g, b};
        if (s == 0) q0.push_back(p);
        else        q1.push_back(p);
    endtask

    task automatic ex(logic [7:0] g, logic s, logic l);
        exp_t e;
        e = '{g, s, l};
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q0.delete();
        q1.delete();
        exp_q.delete();
        tick();
        chk("rst_m_valid", int'(bus.m_valid_o), 0);
        chk("rst_ready", int'(bus.s0_ready_o | bus.s1_ready_o), 0);
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_pops(int n, int lim);
        int k;
        k = 0;
        while (pop_cnt < n && k < lim) begin
            tick();
            k++;
        end
        chk("pop_timeout", int'(pop_cnt >= n), 1);
    endtask

    initial begin
        int pb, hb, c0, c1, k;
        logic [7:0] fg [9];
        fg = '{8'd9, 8'd19, 8'd29, 8'd39, 8'd49, 8'd59, 8'd69, 8'd79, 8'd89};
        bus.en_i      = 1'b1;
        bus.m_ready_i = 1'b1;

        // Reset state, with a source already requesting.
        px(0, 8'd1, 8'd2, 8'd3);
        tick();
        tick();
        chk("rst_err", int'(bus.err_o), 0);
        chk("rst_conv_start", int'(bus.conv_start_o), 0);
        chk("rst_conv_red", int'(bus.conv_red_o), 0);
        chk("rst_m_valid0", int'(bus.m_valid_o), 0);
        chk("rst_s0_ready", int'(bus.s0_ready_o), 0);
        do_reset();

        // Single pixel latency.
        px(0, 8'd255, 8'd255, 8'd255);
        ex(8'd253, 1'b0, 1'b0);
        pb = pop_cnt;
        k = 0;
        while (!hs_q[0] && k < 10) begin
            tick();
            k++;
        end
        chk("lat_hs_seen", int'(hs_q[0]), 1);
        chk("lat_conv_start", int'(bus.conv_start_o), 1);
        chk("lat_conv_red", int'(bus.conv_red_o), 255);
        tick();
        chk("lat_conv_done", int'(bus.conv_done_i), 1);
        chk("lat_conv_gray", int'(bus.conv_gray_i), 253);
        chk("lat_m_valid_early", int'(bus.m_valid_o), 0);
        tick();
        chk("lat_m_valid", int'(bus.m_valid_o), 1);
        chk("lat_m_gray", int'(bus.m_gray_o), 253);
        chk("lat_m_src", int'(bus.m_src_o), 0);
        wait_pops(pb + 1, 10);

        // Both sources valid: strict alternation starting with s0.
        do_reset();
        pb = pop_cnt;
        px(0, 8'd255, 8'd255, 8'd255); px(0, 8'd100, 8'd0, 8'd0); px(0, 8'd0, 8'd100, 8'd0);
        px(1, 8'd0, 8'd0, 8'd100);     px(1, 8'd10, 8'd20, 8'd30); px(1, 8'd200, 8'd100, 8'd50);
        ex(8'd253, 0, 0); ex(8'd11, 1, 0); ex(8'd29, 0, 0);
        ex(8'd18, 1, 0);  ex(8'd58, 0, 0); ex(8'd123, 1, 0);
        wait_pops(pb + 6, 40);

        // Enable low blocks grants.
        do_reset();
        bus.en_i = 1'b0;
        pb = pop_cnt;
        hb = hs_cnt0;
        px(0, 8'd0, 8'd0, 8'd0);
        ex(8'd0, 0, 0);
        repeat (4) tick();
        chk("en_blocked_hs", hs_cnt0 - hb, 0);
        chk("en_blocked_ready", int'(bus.s0_ready_o), 0);
        bus.en_i = 1'b1;
        wait_pops(pb + 1, 10);

        // Backpressure: four accepted, FIFO head held stable.
        do_reset();
        bus.m_ready_i = 1'b0;
        pb = pop_cnt;
        hb = hs_cnt0;
        px(0, 8'd10, 8'd20, 8'd30);   ex(8'd18, 0, 0);
        px(0, 8'd100, 8'd0, 8'd0);    ex(8'd29, 0, 0);
        px(0, 8'd0, 8'd100, 8'd0);    ex(8'd58, 0, 0);
        px(0, 8'd0, 8'd0, 8'd100);    ex(8'd11, 0, 1);
        px(0, 8'd200, 8'd100, 8'd50); ex(8'd123, 0, 0);
        px(0, 8'd128, 8'd128, 8'd128); ex(8'd127, 0, 0);
        repeat (12) tick();
        chk("bp_hs_count", hs_cnt0 - hb, 4);
        chk("bp_s0_ready", int'(bus.s0_ready_o), 0);
        chk("bp_m_valid", int'(bus.m_valid_o), 1);
        chk("bp_head_gray", int'(bus.m_gray_o), 18);
        tick();
        chk("bp_hold_gray", int'(bus.m_gray_o), 18);
        chk("bp_hold_src", int'(bus.m_src_o), 0);
        bus.m_ready_i = 1'b1;
        wait_pops(pb + 6, 30);
        chk("bp_hs_total", hs_cnt0 - hb, 6);

        // Frame of 4 on s1: last tags on pixels 4 and 8, one pixel per cycle.
        do_reset();
        pb = pop_cnt;
        for (int i = 1; i <= 9; i++) begin
            px(1, 8'(10 * i), 8'(10 * i), 8'(10 * i));
            ex(fg[i-1], 1'b1, (i == 4 || i == 8));
        end
        wait_pops(pb + 1, 10);
        c0 = cyc;
        wait_pops(pb + 9, 30);
        c1 = cyc;
        chk("frame_throughput", c1 - c0, 8);

        // Spurious done with nothing issued.
        do_reset();
        pb = pop_cnt;
        tick();
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        repeat (3) tick();
        chk("spur_err", int'(bus.err_o), 1);
        chk("spur_m_valid", int'(bus.m_valid_o), 0);
        chk("spur_no_pop", pop_cnt - pb, 0);
        do_reset();
        chk("spur_err_cleared", int'(bus.err_o), 0);

        // Missing done: error, entry discarded.
        block_done = 1'b1;
        px(0, 8'd50, 8'd150, 8'd250);
        repeat (5) tick();
        chk("miss_err", int'(bus.err_o), 1);
        chk("miss_m_valid", int'(bus.m_valid_o), 0);
        block_done = 1'b0;

        // Reset with pixels buffered; s0 must win afterwards.
        do_reset();
        bus.m_ready_i = 1'b0;
        px(0, 8'd255, 8'd255, 8'd255); px(0, 8'd100, 8'd0, 8'd0); px(0, 8'd0, 8'd100, 8'd0);
        repeat (8) tick();
        chk("mid_m_valid", int'(bus.m_valid_o), 1);
        chk("mid_head_gray", int'(bus.m_gray_o), 253);
        do_reset();
        chk("mid_after_m_valid", int'(bus.m_valid_o), 0);
        bus.m_ready_i = 1'b1;
        pb = pop_cnt;
        px(0, 8'd100, 8'd0, 8'd0); ex(8'd29, 0, 0);
        px(1, 8'd0, 8'd100, 8'd0); ex(8'd58, 1, 0);
        wait_pops(pb + 2, 15);
        chk("mid_err", int'(bus.err_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
